// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
//   Definitions shared by the multi-port register file and its clear sequencer:
//   - clrState_t : clear-sequencer FSM encoding (IDLE=0, CLEAR=1)
//   - addrWidth(): address width helper used to derive AW from DEPTH
//   - ZERO_BIT   : the fill value used to build all-zero words of any width
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_t;

  // Address bits needed to index `depth` entries; at least one bit.
  function automatic int addrWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam logic ZERO_BIT = 1'b0;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
//   Hardware clear sequencer. One clrStart pulse in IDLE starts a sweep that
//   zeroes one entry per cycle, from entry 0 up to entry DEPTH-1, then returns
//   to IDLE. clrStart is ignored while a sweep is running.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clrStart      single-cycle request to start a sweep
//   clrBusy       high for exactly DEPTH cycles while sweeping
//   clrWe         clear strobe for the storage array
//   clrAddr       entry to clear this cycle
//   state         current FSM state (debug / observation)
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = addrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clrStart,
  output logic          clrBusy,
  output logic          clrWe,
  output logic [AW-1:0] clrAddr,
  output clrState_t     state
);

  clrState_t     stateNext;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cntNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The counter is AW bits wide and DEPTH is a power of two, so the increment
  // after the last entry wraps it back to 0 on the way out of CLEAR.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (clrStart) stateNext = CLEAR;
      end
      CLEAR: begin
        cntNext = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign clrBusy = (state == CLEAR);
  assign clrWe   = (state == CLEAR);
  assign clrAddr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file with two write ports, two combinational read
//   ports, write-conflict / dropped-write flags and a hardware clear sweep.
//   Holds FIR coefficients and partial sums between control unit and MAC.
// Parameters:
//   WIDTH     data bits per entry
//   DEPTH     number of entries (power of two, >= 2)
//   AW        address width, derived from DEPTH
//   ZERO_REG  1: entry 0 reads zero and ignores writes
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   wr_en0/wr_addr0/wr_data0         write port 0
//   wr_en1/wr_addr1/wr_data1         write port 1 (wins on same address)
//   rd_addr0/rd_data0, rd_addr1/rd_data1   combinational read ports
//   clr_start / clr_busy             clear request / sweep in progress
//   wr_conflict                      pulse: both ports wrote one address
//   wr_dropped                       pulse: a write was discarded during clear
// Handshake: there is no back-pressure. A write is accepted on the rising edge
//   whenever its enable is high in IDLE; while clr_busy is high every write is
//   discarded and reported through wr_dropped one cycle later.
// Optional feature (macro REGFILE_MP_BYPASS_EN): reads forward the data of an
//   accepted write to the same address in the same cycle (port 1 first).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = addrWidth(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en0,
  input  logic [AW-1:0]    wr_addr0,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic             wr_en1,
  input  logic [AW-1:0]    wr_addr1,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             wr_conflict,
  output logic             wr_dropped
);

  localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{ZERO_BIT}};

  logic [WIDTH-1:0] mem [DEPTH];

  logic          clrWe;
  logic [AW-1:0] clrAddr;
  clrState_t     clrState;
  logic          writesOpen;
  logic          acc0;
  logic          acc1;

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clrStart (clr_start),
    .clrBusy  (clr_busy),
    .clrWe    (clrWe),
    .clrAddr  (clrAddr),
    .state    (clrState)
  );

  // A write is accepted only in IDLE and never to a hard-wired zero entry;
  // zero-entry writes are discarded silently, so they raise no flags either.
  assign writesOpen = (clrState == IDLE);
  assign acc0 = wr_en0 && writesOpen && !((ZERO_REG != 0) && (wr_addr0 == '0));
  assign acc1 = wr_en1 && writesOpen && !((ZERO_REG != 0) && (wr_addr1 == '0));

  // Priority per entry: clear sweep, then port 1, then port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ZERO_WORD;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clrWe && (clrAddr == AW'(i))) begin
          mem[i] <= ZERO_WORD;
        end else if (acc1 && (wr_addr1 == AW'(i))) begin
          mem[i] <= wr_data1;
        end else if (acc0 && (wr_addr0 == AW'(i))) begin
          mem[i] <= wr_data0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_conflict <= 1'b0;
      wr_dropped  <= 1'b0;
    end else begin
      wr_conflict <= acc0 && acc1 && (wr_addr0 == wr_addr1);
      wr_dropped  <= clr_busy && (wr_en0 || wr_en1);
    end
  end

  always_comb begin
    rd_data0 = mem[rd_addr0];
    if ((ZERO_REG != 0) && (rd_addr0 == '0)) rd_data0 = ZERO_WORD;
`ifdef REGFILE_MP_BYPASS_EN
    if (acc1 && (wr_addr1 == rd_addr0)) begin
      rd_data0 = wr_data1;
    end else if (acc0 && (wr_addr0 == rd_addr0)) begin
      rd_data0 = wr_data0;
    end
`endif
  end

  always_comb begin
    rd_data1 = mem[rd_addr1];
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = ZERO_WORD;
`ifdef REGFILE_MP_BYPASS_EN
    if (acc1 && (wr_addr1 == rd_addr1)) begin
      rd_data1 = wr_data1;
    end else if (acc0 && (wr_addr0 == rd_addr1)) begin
      rd_data1 = wr_data0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Self-checking bench for regfile_mp. Two instances share all inputs: one
//   with ZERO_REG=1 (index 1 in the model) and one with ZERO_REG=0 (index 0).
//   The reference model keeps plain arrays of entry contents and a sweep
//   position, updated from the register-file rules once per clock edge.
module tb_regfile_mp;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk;
  logic         rst;
  logic         wrEn0, wrEn1;
  logic [A-1:0] wrAddr0, wrAddr1;
  logic [W-1:0] wrData0, wrData1;
  logic [A-1:0] rdAddr0, rdAddr1;
  logic         clrStart;

  logic [W-1:0] rdZ0, rdZ1, rdN0, rdN1;
  logic         busyZ, busyN, confZ, confN, dropZ, dropN;

  // reference model
  logic [W-1:0] m [2][D];
  int           sweepPos;
  logic         expConf [2];
  logic         expDrop;

  int total;
  int bad;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en0(wrEn0), .wr_addr0(wrAddr0), .wr_data0(wrData0),
    .wr_en1(wrEn1), .wr_addr1(wrAddr1), .wr_data1(wrData1),
    .rd_addr0(rdAddr0), .rd_addr1(rdAddr1),
    .rd_data0(rdZ0), .rd_data1(rdZ1),
    .clr_start(clrStart), .clr_busy(busyZ),
    .wr_conflict(confZ), .wr_dropped(dropZ)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dutNz (
    .clk(clk), .rst(rst),
    .wr_en0(wrEn0), .wr_addr0(wrAddr0), .wr_data0(wrData0),
    .wr_en1(wrEn1), .wr_addr1(wrAddr1), .wr_data1(wrData1),
    .rd_addr0(rdAddr0), .rd_addr1(rdAddr1),
    .rd_data0(rdN0), .rd_data1(rdN1),
    .clr_start(clrStart), .clr_busy(busyN),
    .wr_conflict(confN), .wr_dropped(dropN)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < D; i++) m[z][i] = '0;
      expConf[z] = 1'b0;
    end
    expDrop  = 1'b0;
    sweepPos = -1;
  endtask

  function automatic logic [W-1:0] expRead(input int z, input logic [A-1:0] a);
    logic [W-1:0] v;
    v = (z == 1 && a == 0) ? 8'h00 : m[z][a];
`ifdef REGFILE_MP_BYPASS_EN
    if (sweepPos < 0 && !(z == 1 && a == 0)) begin
      if (wrEn1 && wrAddr1 == a) v = wrData1;
      else if (wrEn0 && wrAddr0 == a) v = wrData0;
    end
`endif
    return v;
  endfunction

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic tick();
    if (sweepPos < 0) begin
      for (int z = 0; z < 2; z++) begin
        bit ok0;
        bit ok1;
        ok0 = wrEn0 && !(z == 1 && wrAddr0 == 0);
        ok1 = wrEn1 && !(z == 1 && wrAddr1 == 0);
        expConf[z] = ok0 && ok1 && (wrAddr0 == wrAddr1);
        if (ok0) m[z][wrAddr0] = wrData0;
        if (ok1) m[z][wrAddr1] = wrData1;
      end
      expDrop = 1'b0;
      if (clrStart) sweepPos = 0;
    end else begin
      for (int z = 0; z < 2; z++) begin
        m[z][sweepPos] = '0;
        expConf[z] = 1'b0;
      end
      expDrop  = wrEn0 || wrEn1;
      sweepPos = sweepPos + 1;
      if (sweepPos == D) sweepPos = -1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wrEn0 = 0; wrEn1 = 0; clrStart = 0;
    wrAddr0 = '0; wrAddr1 = '0; wrData0 = '0; wrData1 = '0;
  endtask

  task automatic drive_write(input int port, input logic [A-1:0] a, input logic [W-1:0] d);
    if (port == 0) begin wrEn0 = 1; wrAddr0 = a; wrData0 = d; end
    else begin wrEn1 = 1; wrAddr1 = a; wrData1 = d; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rdAddr0 = '0; rdAddr1 = '0;
    rst = 0;
    model_reset();
    #3;
    total++; if (busyZ !== 1'b0 || busyN !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b/%b want 0", busyZ, busyN); end
    total++; if (confZ !== 1'b0 || confN !== 1'b0) begin bad++; $display("FAIL reset_conflict: got %b/%b want 0", confZ, confN); end
    total++; if (dropZ !== 1'b0 || dropN !== 1'b0) begin bad++; $display("FAIL reset_dropped: got %b/%b want 0", dropZ, dropN); end
    for (int a = 0; a < D; a++) begin
      rdAddr0 = A'(a); rdAddr1 = A'(D - 1 - a);
      #1;
      total++; if (rdZ0 !== 8'h00 || rdN0 !== 8'h00 || rdZ1 !== 8'h00 || rdN1 !== 8'h00) begin
        bad++; $display("FAIL reset_entries addr %0d: got %h %h %h %h want 00", a, rdZ0, rdN0, rdZ1, rdN1);
      end
    end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_write_read();
    idle_inputs();
    drive_write(0, 3'd3, 8'h15);
    tick();
    idle_inputs();
    rdAddr0 = 3'd3; rdAddr1 = 3'd2;
    #1;
    total++; if (rdZ0 !== 8'h15 || rdN0 !== 8'h15) begin bad++; $display("FAIL write_read addr3: got %h/%h want 15", rdZ0, rdN0); end
    total++; if (rdZ1 !== 8'h00 || rdN1 !== 8'h00) begin bad++; $display("FAIL write_read addr2: got %h/%h want 00", rdZ1, rdN1); end
    tick();
  endtask

  task automatic test_conflict();
    idle_inputs();
    drive_write(0, 3'd5, 8'hAA);
    drive_write(1, 3'd5, 8'h55);
    tick();
    idle_inputs();
    rdAddr0 = 3'd5;
    #1;
    total++; if (rdZ0 !== 8'h55 || rdN0 !== 8'h55) begin bad++; $display("FAIL conflict_data: got %h/%h want 55", rdZ0, rdN0); end
    total++; if (confZ !== 1'b1 || confN !== 1'b1) begin bad++; $display("FAIL conflict_pulse: got %b/%b want 1", confZ, confN); end
    total++; if (dropZ !== 1'b0) begin bad++; $display("FAIL conflict_nodrop: got %b want 0", dropZ); end
    tick();
    total++; if (confZ !== 1'b0 || confN !== 1'b0) begin bad++; $display("FAIL conflict_oneshot: got %b/%b want 0", confZ, confN); end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    drive_write(0, 3'd0, 8'hFF);
    tick();
    idle_inputs();
    rdAddr0 = 3'd0; rdAddr1 = 3'd0;
    #1;
    total++; if (rdZ0 !== 8'h00 || rdZ1 !== 8'h00) begin bad++; $display("FAIL zero_reg_z: got %h/%h want 00", rdZ0, rdZ1); end
    total++; if (rdN0 !== 8'hFF) begin bad++; $display("FAIL zero_reg_n: got %h want ff", rdN0); end
    total++; if (confZ !== 1'b0 || dropZ !== 1'b0) begin bad++; $display("FAIL zero_reg_flags: got %b%b want 00", confZ, dropZ); end
    // both ports to entry 0: discarded on ZERO_REG=1, a real conflict otherwise
    drive_write(0, 3'd0, 8'h12);
    drive_write(1, 3'd0, 8'h34);
    tick();
    idle_inputs();
    #1;
    total++; if (confZ !== 1'b0 || confN !== 1'b1) begin bad++; $display("FAIL zero_reg_conflict: got %b/%b want 0/1", confZ, confN); end
    total++; if (rdZ0 !== 8'h00 || rdN0 !== 8'h34) begin bad++; $display("FAIL zero_reg_both: got %h/%h want 00/34", rdZ0, rdN0); end
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    drive_write(1, 3'd6, 8'h40);
    tick();
    idle_inputs();
    drive_write(0, 3'd6, 8'h7E);
    rdAddr0 = 3'd6;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    total++; if (rdZ0 !== 8'h7E || rdN0 !== 8'h7E) begin bad++; $display("FAIL bypass_same_cycle: got %h/%h want 7e", rdZ0, rdN0); end
`else
    total++; if (rdZ0 !== 8'h40 || rdN0 !== 8'h40) begin bad++; $display("FAIL bypass_same_cycle: got %h/%h want 40", rdZ0, rdN0); end
`endif
    tick();
    idle_inputs();
    #1;
    total++; if (rdZ0 !== 8'h7E || rdN0 !== 8'h7E) begin bad++; $display("FAIL bypass_next_cycle: got %h/%h want 7e", rdZ0, rdN0); end
    tick();
  endtask

  task automatic test_clear();
    int busyCnt;
    idle_inputs();
    for (int p = 0; p < D; p += 2) begin
      drive_write(0, A'(p), 8'h11);
      drive_write(1, A'(p + 1), 8'h11);
      tick();
    end
    idle_inputs();
    clrStart = 1;
    drive_write(0, 3'd2, 8'h99);
    tick();
    busyCnt = 0;
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      clrStart = (c == 1);
      if (c == 2) drive_write(1, 3'd7, 8'hEE);
      rdAddr0 = 3'd7; rdAddr1 = A'(c % D);
      #1;
      total++; if (rdZ0 !== expRead(1, rdAddr0) || rdN0 !== expRead(0, rdAddr0)) begin
        bad++; $display("FAIL clear_read7 c%0d: got %h/%h want %h/%h", c, rdZ0, rdN0, expRead(1, rdAddr0), expRead(0, rdAddr0));
      end
      total++; if (rdZ1 !== expRead(1, rdAddr1) || rdN1 !== expRead(0, rdAddr1)) begin
        bad++; $display("FAIL clear_read c%0d: got %h/%h want %h/%h", c, rdZ1, rdN1, expRead(1, rdAddr1), expRead(0, rdAddr1));
      end
      total++; if (dropZ !== expDrop || dropN !== expDrop) begin bad++; $display("FAIL clear_dropped c%0d: got %b/%b want %b", c, dropZ, dropN, expDrop); end
      total++; if (busyZ !== (sweepPos >= 0) || busyN !== (sweepPos >= 0)) begin
        bad++; $display("FAIL clear_busy c%0d: got %b/%b want %b", c, busyZ, busyN, sweepPos >= 0);
      end
      if (!busyZ) break;
      busyCnt++;
      tick();
    end
    total++; if (busyCnt !== D) begin bad++; $display("FAIL clear_busy_len: got %0d want %0d", busyCnt, D); end
    idle_inputs();
    for (int a = 0; a < D; a++) begin
      rdAddr0 = A'(a);
      #1;
      total++; if (rdZ0 !== 8'h00 || rdN0 !== 8'h00) begin bad++; $display("FAIL clear_result addr %0d: got %h/%h want 00", a, rdZ0, rdN0); end
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    for (int p = 0; p < D; p += 2) begin
      drive_write(0, A'(p), 8'hA5);
      drive_write(1, A'(p + 1), 8'h5A);
      tick();
    end
    idle_inputs();
    clrStart = 1;
    tick();
    clrStart = 0;
    for (int c = 0; c < 3; c++) tick();
    total++; if (busyZ !== 1'b1) begin bad++; $display("FAIL midclear_busy_before: got %b want 1", busyZ); end
    #3;
    rst = 0;
    model_reset();
    #1;
    total++; if (busyZ !== 1'b0 || busyN !== 1'b0) begin bad++; $display("FAIL midclear_busy: got %b/%b want 0", busyZ, busyN); end
    for (int a = 0; a < D; a++) begin
      rdAddr0 = A'(a);
      #1;
      total++; if (rdZ0 !== 8'h00 || rdN0 !== 8'h00) begin bad++; $display("FAIL midclear_entry %0d: got %h/%h want 00", a, rdZ0, rdN0); end
    end
    @(posedge clk);
    #1;
    rst = 1;
    drive_write(0, 3'd4, 8'h3C);
    tick();
    idle_inputs();
    rdAddr1 = 3'd4;
    #1;
    total++; if (rdZ1 !== 8'h3C || rdN1 !== 8'h3C) begin bad++; $display("FAIL midclear_write: got %h/%h want 3c", rdZ1, rdN1); end
    total++; if (busyZ !== 1'b0 || dropZ !== 1'b0) begin bad++; $display("FAIL midclear_flags: got %b%b want 00", busyZ, dropZ); end
    tick();
  endtask

  task automatic test_random(input int cycles, input int clrOdds);
    for (int c = 0; c < cycles; c++) begin
      wrEn0    = ($urandom_range(0, 2) != 0);
      wrEn1    = ($urandom_range(0, 2) != 0);
      wrAddr0  = A'($urandom_range(0, D - 1));
      wrAddr1  = ($urandom_range(0, 3) == 0) ? wrAddr0 : A'($urandom_range(0, D - 1));
      wrData0  = W'($urandom);
      wrData1  = W'($urandom);
      clrStart = (clrOdds != 0) && ($urandom_range(1, clrOdds) == 1);
      rdAddr0  = ($urandom_range(0, 2) == 0) ? wrAddr0 : A'($urandom_range(0, D - 1));
      rdAddr1  = ($urandom_range(0, 2) == 0) ? wrAddr1 : A'($urandom_range(0, D - 1));
      #1;
      total++; if (rdZ0 !== expRead(1, rdAddr0) || rdN0 !== expRead(0, rdAddr0)) begin
        bad++; $display("FAIL rand_rd0 c%0d a%0d: got %h/%h want %h/%h", c, rdAddr0, rdZ0, rdN0, expRead(1, rdAddr0), expRead(0, rdAddr0));
      end
      total++; if (rdZ1 !== expRead(1, rdAddr1) || rdN1 !== expRead(0, rdAddr1)) begin
        bad++; $display("FAIL rand_rd1 c%0d a%0d: got %h/%h want %h/%h", c, rdAddr1, rdZ1, rdN1, expRead(1, rdAddr1), expRead(0, rdAddr1));
      end
      total++; if (confZ !== expConf[1] || confN !== expConf[0]) begin
        bad++; $display("FAIL rand_conflict c%0d: got %b/%b want %b/%b", c, confZ, confN, expConf[1], expConf[0]);
      end
      total++; if (dropZ !== expDrop || dropN !== expDrop) begin bad++; $display("FAIL rand_dropped c%0d: got %b/%b want %b", c, dropZ, dropN, expDrop); end
      total++; if (busyZ !== (sweepPos >= 0) || busyN !== (sweepPos >= 0)) begin
        bad++; $display("FAIL rand_busy c%0d: got %b/%b want %b", c, busyZ, busyN, sweepPos >= 0);
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    idle_inputs();
    rdAddr0 = '0;
    rdAddr1 = '0;
    #2;
    test_reset();
    test_write_read();
    test_conflict();
    test_zero_reg();
    test_bypass();
    test_random(200, 0);
    test_clear();
    test_reset_mid_clear();
    test_random(400, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
